// File: rtl/mem_line_adapter.sv
// mem_line_adapter: turns single-word CPU requests into line bursts on the physical port; stores are line read-modify-write.
// Build option MEM_LINE_BUF_EN keeps the last line as a one-entry buffer (read hits, write-through on stores).
module mem_line_adapter #(
   parameter int BEAT_W = 64,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       mem_address,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_byte_enable,
   output logic [31:0]       mem_rdata,
   output logic              mem_resp,
   output logic [31:0]       pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [BEAT_W-1:0] pmem_wdata,
   input  logic [BEAT_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int LINE_W     = BEAT_W * BEATS;
   localparam int LINE_BYTES = LINE_W / 8;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int IDX_W      = OFF_W - 2;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {IDLE, RD_BURST, MERGE, WR_BURST, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [LINE_W-1:0] line_q;
   logic [31:2]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;
   logic              write_q;
   logic              last_beat;
   logic              beat_fire;
   logic              hit;
   logic [IDX_W-1:0]  word_idx;
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^mem_address[1:0];
   assign word_idx  = addr_q[OFF_W-1:2];
   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
   assign beat_fire = pmem_resp && (state_q == RD_BURST || state_q == WR_BURST);

`ifdef MEM_LINE_BUF_EN
   logic            valid_q;
   logic [31:OFF_W] tag_q;

   assign hit = valid_q && (tag_q == mem_address[31:OFF_W]);
`else
   assign hit = 1'b0;
`endif

   assign mem_resp     = (state_q == RESP);
   assign pmem_read    = (state_q == RD_BURST);
   assign pmem_write   = (state_q == WR_BURST);
   assign pmem_address = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
   assign pmem_wdata   = line_q[int'(cnt_q) * BEAT_W +: BEAT_W];
   assign mem_rdata    = line_q[int'(word_idx) * 32 +: 32];

   always_comb begin
      // NOTE: state_d gets its default before the case so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            // A write wins when both requests are high.
            if (mem_write) begin
               if (mem_byte_enable == 4'b0000) state_d = RESP;
               else if (hit)                   state_d = MERGE;
               else                            state_d = RD_BURST;
            end else if (mem_read) begin
               state_d = hit ? RESP : RD_BURST;
            end
         end
         RD_BURST: if (pmem_resp && last_beat) state_d = write_q ? MERGE : RESP;
         MERGE:    state_d = WR_BURST;
         WR_BURST: if (pmem_resp && last_beat) state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: the line buffer is a flat register, not a RAM macro, so it is reset along with the control state.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d != IDLE) begin
            addr_q  <= mem_address[31:2];
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            write_q <= mem_write;
         end
         if (beat_fire) cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
         if (state_q == RD_BURST && pmem_resp) line_q[int'(cnt_q) * BEAT_W +: BEAT_W] <= pmem_rdata;
         if (state_q == MERGE) begin
            for (int i = 0; i < 4; i++) begin
               if (be_q[i]) line_q[int'(word_idx) * 32 + i * 8 +: 8] <= wdata_q[i * 8 +: 8];
            end
         end
      end
   end

`ifdef MEM_LINE_BUF_EN
   // The buffer is invalid while a refill is in flight, so an abandoned burst never leaves a stale hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else if (state_q == IDLE && state_d == RD_BURST) begin
         valid_q <= 1'b0;
      end else if (state_q == RD_BURST && pmem_resp && last_beat) begin
         valid_q <= 1'b1;
         tag_q   <= addr_q[31:OFF_W];
      end
   end
`endif

endmodule
